// File: rtl/seq_alu_pkg.sv
// Shared op encodings and FSM state type for the sequential ALU.
// Op 8 (MUL) is only decoded when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLT = 4'd6,
    OP_EQ  = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and op in, result and flags out.
// Valid/ready on both sides; master is the requester/consumer.
interface seq_alu_if #(parameter int WIDTH = 4);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cf;
  logic             of;
  logic             zf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cf, of, zf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cf, of, zf
  );

endinterface

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier: WIDTH iterations, first one folded into the start cycle,
// so done is high WIDTH-1 cycles after start; no backpressure, product held until next start.
module seq_alu_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  assign done    = busy && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake: ALU ops 1 cycle, MUL (SEQ_ALU_MUL_EN) WIDTH+1 cycles.
// One op in flight; result and flags hold in DONE until out_ready, in_ready only in IDLE.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] res_q;
  logic             cf_q, of_q, zf_q;
  logic             out_valid_q, in_ready_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of;
  logic [WIDTH:0]   sum, diff;

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op_e'(bus.op))
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_cf  = sum[WIDTH];
        alu_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_cf  = diff[WIDTH];
        alu_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~bus.a;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = (state == IDLE) && bus.in_valid && (bus.op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      res_q       <= '0;
      cf_q        <= 1'b0;
      of_q        <= 1'b0;
      zf_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            if (bus.op == OP_MUL) state <= CALC; else
`endif
            begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= alu_res;
              cf_q        <= alu_cf;
              of_q        <= alu_of;
              zf_q        <= (alu_res == '0);
            end
          end
        end
        CALC: begin
`ifdef SEQ_ALU_MUL_EN
          if (mul_done) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= mul_prod[WIDTH-1:0];
            cf_q        <= 1'b0;
            of_q        <= |mul_prod[2*WIDTH-1:WIDTH];
            zf_q        <= (mul_prod[WIDTH-1:0] == '0);
          end
`else
          state      <= IDLE;
          in_ready_q <= 1'b1;
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.cf        = cf_q;
  assign bus.of        = of_q;
  assign bus.zf        = zf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu (WIDTH=4) against an arithmetic reference model.
// MUL expectations follow SEQ_ALU_MUL_EN as defined for the build.
module tb_seq_alu;

  localparam int W = 4;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {result, cf, of, zf} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input int ua, input int ub, input int opc);
    int m, sa, sb, t, r, c, o;
    m  = 1 << W;
    sa = (ua >= m/2) ? ua - m : ua;
    sb = (ub >= m/2) ? ub - m : ub;
    r = 0; c = 0; o = 0;
    case (opc)
      0: begin t = ua + ub; r = t % m; c = int'(t >= m);
               o = int'((sa + sb > m/2 - 1) || (sa + sb < -m/2)); end
      1: begin r = (ua - ub + m) % m; c = int'(ua < ub);
               o = int'((sa - sb > m/2 - 1) || (sa - sb < -m/2)); end
      2: r = m - 1 - ua;
      3: r = ua & ub;
      4: r = ua | ub;
      5: r = ua ^ ub;
      6: r = int'(sa < sb);
      7: r = int'(ua == ub);
      8: if (MUL_ON) begin t = ua * ub; r = t % m; o = int'(t >= m); end
      default: r = 0;
    endcase
    return {r[W-1:0], c[0], o[0], (r == 0)};
  endfunction

  function automatic int exp_lat(input int opc);
    return (MUL_ON && opc == 8) ? W + 1 : 1;
  endfunction

  // Issue one request, wait (bounded) for out_valid, capture outputs, then consume.
  task automatic run_op(input int ua, input int ub, input int opc,
                        output int lat, output logic [W+2:0] obs);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = ua[W-1:0];
    bus.b        = ub[W-1:0];
    bus.op       = opc[3:0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    obs = {bus.result, bus.cf, bus.of, bus.zf};
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid,in_ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    n_checks++;
    if ({bus.result, bus.cf, bus.of, bus.zf} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_out: result/cf/of/zf=%b expected 0", {bus.result, bus.cf, bus.of, bus.zf});
    end
  endtask

  task automatic test_directed();
    int dop[6] = '{0, 1, 1, 6, 7, 12};
    int da[6]  = '{7, 0, 5, 8, 3, 5};
    int db[6]  = '{1, 1, 5, 1, 3, 2};
    logic [6:0] dexp[6] = '{{4'd8, 3'b010}, {4'd15, 3'b100}, {4'd0, 3'b001},
                            {4'd1, 3'b000}, {4'd1, 3'b000}, {4'd0, 3'b001}};
    int lat;
    logic [W+2:0] obs;
    for (int i = 0; i < 6; i++) begin
      run_op(da[i], db[i], dop[i], lat, obs);
      n_checks++;
      if (obs !== dexp[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: op=%0d a=%0d b=%0d got %b expected %b", i, dop[i], da[i], db[i], obs, dexp[i]);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL directed_lat_%0d: latency %0d expected 1", i, lat);
      end
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [W+2:0] obs;
`ifdef SEQ_ALU_MUL_EN
    int ma[2] = '{5, 5};
    int mb[2] = '{3, 5};
    logic [6:0] mexp[2] = '{{4'd15, 3'b000}, {4'd9, 3'b010}};
    for (int i = 0; i < 2; i++) begin
      run_op(ma[i], mb[i], 8, lat, obs);
      n_checks++;
      if (obs !== mexp[i] || lat !== W + 1) begin
        n_fail++;
        $display("FAIL mul_%0d: got %b lat %0d expected %b lat %0d", i, obs, lat, mexp[i], W + 1);
      end
    end
`else
    run_op(5, 3, 8, lat, obs);
    n_checks++;
    if (obs !== {4'd0, 3'b001} || lat !== 1) begin
      n_fail++;
      $display("FAIL op8_illegal: got %b lat %0d expected 0000001 lat 1", obs, lat);
    end
`endif
  endtask

  task automatic test_random();
    int ua, ub, opc, lat;
    logic [W+2:0] obs, exp_v;
    for (int i = 0; i < 40; i++) begin
      ua  = $urandom_range(0, 15);
      ub  = $urandom_range(0, 15);
      opc = $urandom_range(0, 15);
      exp_v = model(ua, ub, opc);
      run_op(ua, ub, opc, lat, obs);
      n_checks++;
      if (obs !== exp_v || lat !== exp_lat(opc)) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d a=%0d b=%0d got %b lat %0d expected %b lat %0d",
                 i, opc, ua, ub, obs, lat, exp_v, exp_lat(opc));
      end
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: out_valid,in_ready=%b expected 01", i, {bus.out_valid, bus.in_ready});
      end
    end
  endtask

  task automatic test_hold();
    logic [W+2:0] exp_v;
    int lat;
    int seen;
    exp_v = model(3, 4, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 4'd3; bus.b = 4'd4; bus.op = 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.of, bus.zf} !== {2'b10, exp_v}) begin
        n_fail++;
        $display("FAIL hold_%0d: got %b expected %b", i,
                 {bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.of, bus.zf}, {2'b10, exp_v});
      end
      bus.in_valid = (i != 1);
      bus.a  = 4'($urandom_range(0, 15));
      bus.op = 4'd1;
      if (i < 3) @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_release: out_valid,in_ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL hold_ignored: out_valid seen %0d cycles expected 0", seen);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 4'd5; bus.b = 4'd3;
    bus.op = MUL_ON ? 4'd8 : 4'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.of, bus.zf} !== 9'b01_0000_000) begin
      n_fail++;
      $display("FAIL abort_state: got %b expected 010000000",
               {bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.of, bus.zf});
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid seen %0d cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_random();
    test_hold();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; legal values 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A, two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B, two's complement.
REQ-008 SHALL have port op  input  4  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports cf, of, zf  output  1 each  carry/borrow, signed overflow, zero.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL capture a, b, op on in_valid && in_ready; other inputs are ignored.
REQ-015 Ops 0-7 (ADD, SUB, NOT a, AND, OR, XOR, SLT, EQ) SHALL go IDLE->DONE with 1-cycle latency: out_valid high the cycle after acceptance.
REQ-016 ADD: cf = unsigned carry-out; of = signed overflow.
REQ-017 SUB: result = a-b modulo 2^WIDTH; cf = 1 when a<b unsigned (borrow); of = signed overflow.
REQ-018 SLT: result = 1 when a<b signed, else 0; EQ: result = 1 when a==b, else 0; NOT/AND/OR/XOR/SLT/EQ: cf = of = 0.
REQ-019 zf SHALL be 1 exactly when result == 0, for every op.
REQ-020 Illegal op codes SHALL produce result 0, cf = of = 0, zf = 1, 1-cycle latency, no hang.
REQ-021 In DONE, out_valid, result, and flags SHALL stay stable until out_ready is sampled high, then go to IDLE with out_valid low next cycle.
REQ-022 No new request SHALL be accepted in CALC or DONE; back-to-back throughput is one operation per (latency+1) cycles minimum.

Reset
REQ-023 On rst high at a clock edge: state SHALL be IDLE, result = 0, cf = of = zf = 0, out_valid = 0, in_ready = 1 on the next cycle.
REQ-024 Reset during CALC or DONE SHALL abort the operation; no result SHALL be presented after reset.

Configuration
REQ-025 Macro SEQ_ALU_MUL_EN defined: op 8 = MUL, unsigned iterative shift-add, IDLE->CALC for WIDTH cycles then DONE (out_valid WIDTH+1 cycles after acceptance); result = low WIDTH bits of product; of = 1 when high WIDTH bits nonzero; cf = 0.
REQ-026 Macro SEQ_ALU_MUL_EN undefined: op 8 SHALL be illegal per REQ-020 and CALC SHALL be unreachable.

Structure
REQ-027 Package seq_alu_pkg SHALL hold op encodings (OP_ADD=0 ... OP_EQ=7, OP_MUL=8) and the FSM state typedef.
REQ-028 The multiplier SHALL be a sub-module seq_alu_mul (start, done, WIDTH-cycle shift-add datapath), instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=4)
REQ-029 ADD a=7, b=1 -> result 8, of=1, cf=0, zf=0, out_valid 1 cycle after accept.
REQ-030 SUB a=0, b=1 -> result 15, cf=1, of=0; SUB a=5, b=5 -> result 0, zf=1.
REQ-031 SLT a=8 (-8), b=1 -> result 1; EQ a=3, b=3 -> 1; op=12 -> result 0, zf=1.
REQ-032 With MUL_EN: 5*3 -> 15, of=0, out_valid at cycle 5 after accept; 5*5 -> 9, of=1; without MUL_EN op 8 -> result 0, zf=1.
REQ-033 Hold out_ready low 3 cycles in DONE -> result/flags stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-034 Assert rst in cycle 2 of a MUL -> out_valid never rises for it, all outputs 0, in_ready=1 next cycle.
